trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the PC/instruction/data width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter POST_TRIG, default 8, meaning the number of entries captured after the trigger entry; it must be in the range 0..DEPTH-1.
REQ-004 The block SHALL have parameter REG_AW, default 4, meaning the register-file address width.
REQ-005 The block SHALL have the following ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse that starts a new capture.
- mode  in  1  capture mode, sampled when arm is high: 0 = post-trigger only, 1 = circular pre-trigger plus post-trigger.
- trig_en  in  1  sampled when arm is high: 0 = trigger on the first retire.
- trig_pc  in  ADDR_W  trigger PC, sampled when arm is high.
- retire  in  1  one instruction retired this cycle.
- pc, instr  in  ADDR_W each  PC and encoding of the retired instruction.
- rf_we  in  1  register-file write flag of the retired instruction.
- rf_wa  in  REG_AW  register-file write address.
- rf_wd  in  ADDR_W  register-file write data.
- mem_we  in  1  memory write flag of the retired instruction.
- rd_en  in  1  readout request.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  ENTRY_W  one captured entry, where ENTRY_W = 3*ADDR_W+REG_AW+2.
- count  out  clog2(DEPTH+1)  number of stored entries.
- state  out  2  current FSM state.
- overflow  out  1  sticky flag: entries were overwritten.

Function
REQ-006 Entry packing SHALL be, MSB to LSB: {pc, instr, rf_wd, rf_wa, rf_we, mem_we}.
REQ-007 The FSM states SHALL be IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
REQ-008 An arm pulse in any state SHALL:
- clear the pointers, count, overflow and the post-trigger counter;
- latch mode, trig_en and trig_pc;
- move the FSM to ARMED on the next edge.
REQ-009 A retire in the same cycle as arm SHALL be ignored, because arm has priority.
REQ-010 A trigger SHALL fire in ARMED when retire=1 and either trig_en=0 or pc==trig_pc.
REQ-011 On the trigger, the trigger entry SHALL be written and the FSM SHALL go to TRIGGERED, or directly to DONE if POST_TRIG=0.
REQ-012 In ARMED with mode=1, every non-trigger retire SHALL be written into the circular buffer.
REQ-013 In ARMED with mode=0, non-trigger retires SHALL NOT be written.
REQ-014 In TRIGGERED, each retire SHALL be written and SHALL increment the post-trigger counter; the write that makes the counter equal POST_TRIG SHALL move the FSM to DONE on the same edge.
REQ-015 Retires in IDLE or DONE SHALL be ignored.
REQ-016 A write when count==DEPTH SHALL overwrite the oldest entry, advance the read pointer, leave count at DEPTH and set overflow; this can occur in mode=1 only.
REQ-017 Write latency SHALL be one cycle: count reflects a write on the edge that stores it.
REQ-018 Readout SHALL be enabled only in DONE.
REQ-019 rd_en=1 with count>0 SHALL cause rd_valid=1 on the next cycle, with rd_data equal to the oldest entry; count SHALL decrement on the edge that accepts the request.
REQ-020 rd_en with count==0, or outside DONE, SHALL be ignored: rd_valid=0 and no pointer change.
REQ-021 rd_valid SHALL be a one-cycle pulse per accepted request; back-to-back rd_en SHALL stream one entry per cycle.
REQ-022 Entries SHALL be read out oldest first, in retire order.
REQ-023 The FSM SHALL remain in DONE after a full drain until the next arm.
REQ-024 Pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-025 reset SHALL asynchronously force: state=IDLE, count=0, overflow=0, rd_valid=0, rd_data=0, pointers=0, post-trigger counter=0, and latched config=0.
REQ-026 Storage array contents SHALL NOT be reset.
REQ-027 Reset asserted mid-capture or mid-readout SHALL discard all entries; after release the block SHALL wait in IDLE for arm.

Structure
REQ-028 A shared package trace_pkg SHALL hold the state enum (IDLE, ARMED, TRIGGERED, DONE) and the entry field-offset helper constants.
REQ-029 The storage SHALL be a sub-module trace_mem: a simple dual-port RAM, DEPTH x ENTRY_W, with one write port, one registered read port and no reset.

Verification
REQ-030 Post-trigger only: reset, arm with mode=0, trig_en=1, trig_pc=0x20; retire pc 0x00..0x3C in steps of 4 -> DONE after pc 0x40 is absent and 9 entries are stored (0x20..0x40 requires 9 retires); with the stream ending at 0x3C -> state stays TRIGGERED with count=8, pc 0x20..0x3C.
REQ-031 Circular wrap: mode=1, trig_pc=0x80; retire pc 0x00..0xA0 in steps of 4 -> DONE at pc 0xA0, count=16, overflow=1; readout yields 0x64..0xA0 in order with 16 rd_valid pulses.
REQ-032 Immediate trigger: trig_en=0, POST_TRIG=8, retire pc 0x100.. -> trigger entry is 0x100 and DONE is reached after pc 0x120.
REQ-033 Arm priority and restart: arm and retire in the same cycle -> retire dropped; re-arm in TRIGGERED with count=5 -> next cycle count=0, state=ARMED, overflow=0.
REQ-034 Readout edges: rd_en in ARMED -> no rd_valid; in DONE, drain until count=0, then one more rd_en -> rd_valid=0 and count stays 0.
REQ-035 Async reset: assert reset between clock edges during TRIGGERED -> state=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer.
//   - trace_state_e : capture FSM encoding, also driven on the 'state' output
//   - *_OFS / *_ofs : bit offsets of each field inside a packed trace entry
//   - entry_width   : total entry width for a given PC/data width and RF address width
// Entry layout, MSB to LSB: {pc, instr, rf_wd, rf_wa, rf_we, mem_we}
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } trace_state_e;

    localparam int MEM_WE_OFS = 0;
    localparam int RF_WE_OFS  = 1;
    localparam int RF_WA_OFS  = 2;

    function automatic int rf_wd_ofs(input int reg_aw);
        return 2 + reg_aw;
    endfunction

    function automatic int instr_ofs(input int addr_w, input int reg_aw);
        return 2 + reg_aw + addr_w;
    endfunction

    function automatic int pc_ofs(input int addr_w, input int reg_aw);
        return 2 + reg_aw + 2 * addr_w;
    endfunction

    function automatic int entry_width(input int addr_w, input int reg_aw);
        return 3 * addr_w + reg_aw + 2;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// Trace entry storage: simple dual-port RAM, DEPTH x WIDTH.
// One write port and one registered read port, single clock, no reset
// (contents are don't-care until written).
// Ports:
//   clk_i    clock
//   we_i     write enable, waddr_i/wdata_i written on the rising edge
//   re_i     read enable, rdata_o updated with mem[raddr_i] on the rising edge
module trace_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 102
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// Instruction retire trace buffer.
// Captures retired-instruction records around a PC trigger, either
// post-trigger only (mode=0) or with a circular pre-trigger history (mode=1),
// then lets software drain the captured entries oldest first.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   arm, mode, trig_en, trig_pc  start a capture and its configuration
//   retire, pc, instr, rf_we, rf_wa, rf_wd, mem_we  retired-instruction record
//   rd_en                      readout request (honoured in DONE only)
//   rd_valid, rd_data          one entry per accepted request, next cycle
//   count                      number of stored entries
//   state                      FSM state (trace_pkg::trace_state_e)
//   overflow                   sticky: an old entry was overwritten
// Parameters: DEPTH must be a power of two >= 2, POST_TRIG in 0..DEPTH-1.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int REG_AW    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arm,
    input  logic                          mode,
    input  logic                          trig_en,
    input  logic [ADDR_W-1:0]             trig_pc,
    input  logic                          retire,
    input  logic [ADDR_W-1:0]             pc,
    input  logic [ADDR_W-1:0]             instr,
    input  logic                          rf_we,
    input  logic [REG_AW-1:0]             rf_wa,
    input  logic [ADDR_W-1:0]             rf_wd,
    input  logic                          mem_we,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [3*ADDR_W+REG_AW+1:0]    rd_data,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [1:0]                    state,
    output logic                          overflow
);

    localparam int ENTRY_W = entry_width(ADDR_W, REG_AW);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_TRIG);

    trace_state_e       state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
    logic               overflow_q, overflow_d;
    logic               mode_q, mode_d;
    logic               trig_en_q, trig_en_d;
    logic [ADDR_W-1:0]  trig_pc_q, trig_pc_d;
    logic               rd_valid_q, rd_valid_d;

    logic               wr_en;
    logic               rd_acc;
    logic               trig_hit;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] mem_rdata;

    assign wr_entry = {pc, instr, rf_wd, rf_wa, rf_we, mem_we};
    assign trig_hit = retire && (!trig_en_q || (pc == trig_pc_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
            trig_en_q  <= 1'b0;
            trig_pc_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            trig_en_q  <= trig_en_d;
            trig_pc_q  <= trig_pc_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        trig_en_d  = trig_en_q;
        trig_pc_d  = trig_pc_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;
        rd_acc     = 1'b0;

        if (arm) begin
            // arm wins over anything else this cycle, including a retire
            state_d    = ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
            mode_d     = mode;
            trig_en_d  = trig_en;
            trig_pc_d  = trig_pc;
        end else begin
            case (state_q)
                ARMED: begin
                    if (trig_hit) begin
                        wr_en   = 1'b1;
                        state_d = (POST_TRIG == 0) ? DONE : TRIGGERED;
                    end else if (retire && mode_q) begin
                        wr_en = 1'b1;
                    end
                end
                TRIGGERED: begin
                    if (retire) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q + CNT_W'(1);
                        if (post_cnt_d == POST_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (rd_en && (count_q != '0)) begin
                        rd_acc = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Writes and reads live in disjoint states, so they never collide.
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (count_q == FULL_CNT) begin
                    // full ring: drop the oldest entry to make room
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                count_d    = count_q - CNT_W'(1);
                rd_valid_d = 1'b1;
            end
        end
    end

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // The RAM output is not reset, so gate it with rd_valid to give a
    // clean zero whenever no entry is being presented (including in reset).
    assign rd_data  = rd_valid_q ? mem_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

    localparam int AW = 32;
    localparam int RAW = 4;
    localparam int EW = 3 * AW + RAW + 2;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          mode = 1'b0;
    logic          trig_en = 1'b0;
    logic [AW-1:0] trig_pc = '0;
    logic          retire = 1'b0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] instr = '0;
    logic          rf_we = 1'b0;
    logic [RAW-1:0] rf_wa = '0;
    logic [AW-1:0] rf_wd = '0;
    logic          mem_we = 1'b0;
    logic          rd_en = 1'b0;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic          overflow;

    int n_chk = 0;
    int n_fail = 0;

    trace_buffer #(
        .ADDR_W(AW), .DEPTH(16), .POST_TRIG(8), .REG_AW(RAW)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_en(trig_en),
        .trig_pc(trig_pc), .retire(retire), .pc(pc), .instr(instr),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .mem_we(mem_we),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          arm;
        logic          mode;
        logic          trig_en;
        logic [AW-1:0] trig_pc;
        logic          retire;
        logic [AW-1:0] pc;
        logic          rd_en;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic          ovf;
        logic          rv;
        logic [AW-1:0] dpc;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t v(input logic a, input logic m, input logic te,
                               input logic [AW-1:0] tp, input logic r,
                               input logic [AW-1:0] p, input logic re,
                               input logic [1:0] s, input logic [CW-1:0] c,
                               input logic o, input logic rv,
                               input logic [AW-1:0] dpc);
        vec_t x;
        x.arm = a; x.mode = m; x.trig_en = te; x.trig_pc = tp; x.retire = r;
        x.pc = p; x.rd_en = re; x.st = s; x.cnt = c; x.ovf = o; x.rv = rv;
        x.dpc = dpc;
        return x;
    endfunction

    function automatic logic [EW-1:0] mk_entry(input logic [AW-1:0] p);
        logic [AW-1:0] ins;
        logic [AW-1:0] wd;
        ins = p ^ 32'hA5A5_0000;
        wd  = ~p;
        return {p, ins, wd, p[5:2], p[2], p[3]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input logic [AW-1:0] p);
        retire = 1'b1;
        pc     = p;
        instr  = p ^ 32'hA5A5_0000;
        rf_wd  = ~p;
        rf_wa  = p[5:2];
        rf_we  = p[2];
        mem_we = p[3];
    endtask

    task automatic do_retire(input logic [AW-1:0] p);
        set_ret(p);
        step();
        retire = 1'b0;
    endtask

    task automatic do_arm(input logic m, input logic te, input logic [AW-1:0] tp);
        arm = 1'b1; mode = m; trig_en = te; trig_pc = tp;
        step();
        arm = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
    endtask

    initial begin
        // ---- table: arm priority, re-arm, mode 0/1 filtering, readout gating
        vecs[0]  = v(1, 0, 1, 32'h10, 0, 32'h00, 0, 2'd1, 5'd0, 0, 0, 0);
        vecs[1]  = v(1, 0, 1, 32'h10, 1, 32'h10, 0, 2'd1, 5'd0, 0, 0, 0);
        vecs[2]  = v(0, 0, 0, 32'h00, 1, 32'h08, 0, 2'd1, 5'd0, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 32'h00, 0, 32'h00, 1, 2'd1, 5'd0, 0, 0, 0);
        vecs[4]  = v(0, 0, 0, 32'h00, 1, 32'h10, 0, 2'd2, 5'd1, 0, 0, 0);
        vecs[5]  = v(0, 0, 0, 32'h00, 1, 32'h14, 0, 2'd2, 5'd2, 0, 0, 0);
        vecs[6]  = v(0, 0, 0, 32'h00, 1, 32'h18, 0, 2'd2, 5'd3, 0, 0, 0);
        vecs[7]  = v(0, 0, 0, 32'h00, 1, 32'h1C, 0, 2'd2, 5'd4, 0, 0, 0);
        vecs[8]  = v(0, 0, 0, 32'h00, 1, 32'h20, 0, 2'd2, 5'd5, 0, 0, 0);
        vecs[9]  = v(1, 1, 1, 32'h30, 0, 32'h00, 0, 2'd1, 5'd0, 0, 0, 0);
        vecs[10] = v(0, 0, 0, 32'h00, 1, 32'h24, 0, 2'd1, 5'd1, 0, 0, 0);
        vecs[11] = v(0, 0, 0, 32'h00, 1, 32'h28, 0, 2'd1, 5'd2, 0, 0, 0);
        vecs[12] = v(0, 0, 0, 32'h00, 0, 32'h00, 1, 2'd1, 5'd2, 0, 0, 0);
        vecs[13] = v(0, 0, 0, 32'h00, 1, 32'h30, 0, 2'd2, 5'd3, 0, 0, 0);
        vecs[14] = v(0, 0, 0, 32'h00, 1, 32'h34, 0, 2'd2, 5'd4, 0, 0, 0);
        vecs[15] = v(0, 0, 0, 32'h00, 1, 32'h38, 0, 2'd2, 5'd5, 0, 0, 0);
        vecs[16] = v(0, 0, 0, 32'h00, 1, 32'h3C, 0, 2'd2, 5'd6, 0, 0, 0);
        vecs[17] = v(0, 0, 0, 32'h00, 1, 32'h40, 0, 2'd2, 5'd7, 0, 0, 0);
        vecs[18] = v(0, 0, 0, 32'h00, 1, 32'h44, 0, 2'd2, 5'd8, 0, 0, 0);
        vecs[19] = v(0, 0, 0, 32'h00, 1, 32'h48, 0, 2'd2, 5'd9, 0, 0, 0);
        vecs[20] = v(0, 0, 0, 32'h00, 1, 32'h4C, 0, 2'd2, 5'd10, 0, 0, 0);
        vecs[21] = v(0, 0, 0, 32'h00, 1, 32'h50, 0, 2'd3, 5'd11, 0, 0, 0);
        vecs[22] = v(0, 0, 0, 32'h00, 1, 32'h54, 0, 2'd3, 5'd11, 0, 0, 0);
        vecs[23] = v(0, 0, 0, 32'h00, 0, 32'h00, 1, 2'd3, 5'd10, 0, 1, 32'h24);
        vecs[24] = v(0, 0, 0, 32'h00, 0, 32'h00, 1, 2'd3, 5'd9, 0, 1, 32'h28);
        vecs[25] = v(0, 0, 0, 32'h00, 0, 32'h00, 0, 2'd3, 5'd9, 0, 0, 0);

        // ---- reset values
        #12;
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_rv", 128'(rd_valid), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        #1 reset = 1'b0;
        step();

        // retire in IDLE is ignored
        do_retire(32'h10);
        chk("idle_state", 128'(state), 128'(0));
        chk("idle_count", 128'(count), 128'(0));

        // ---- table-driven vectors
        for (int i = 0; i < 26; i++) begin
            arm = vecs[i].arm; mode = vecs[i].mode; trig_en = vecs[i].trig_en;
            trig_pc = vecs[i].trig_pc; rd_en = vecs[i].rd_en;
            if (vecs[i].retire) set_ret(vecs[i].pc);
            else retire = 1'b0;
            step();
            chk($sformatf("vec%0d_state", i), 128'(state), 128'(vecs[i].st));
            chk($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].cnt));
            chk($sformatf("vec%0d_ovf", i), 128'(overflow), 128'(vecs[i].ovf));
            chk($sformatf("vec%0d_rv", i), 128'(rd_valid), 128'(vecs[i].rv));
            if (vecs[i].rv) chk($sformatf("vec%0d_data", i), 128'(rd_data), 128'(mk_entry(vecs[i].dpc)));
        end
        arm = 1'b0; retire = 1'b0; rd_en = 1'b0;

        // ---- post-trigger only capture
        reset = 1'b1; #2 reset = 1'b0;
        step();
        do_arm(1'b0, 1'b1, 32'h20);
        for (int p = 0; p <= 32'h3C; p += 4) do_retire(AW'(p));
        chk("post_state_3c", 128'(state), 128'(2));
        chk("post_count_3c", 128'(count), 128'(8));
        do_retire(32'h40);
        chk("post_state_40", 128'(state), 128'(3));
        chk("post_count_40", 128'(count), 128'(9));
        for (int i = 0; i < 9; i++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("post_rv%0d", i), 128'(rd_valid), 128'(1));
            chk($sformatf("post_data%0d", i), 128'(rd_data), 128'(mk_entry(AW'(32'h20 + 4 * i))));
            chk($sformatf("post_cnt%0d", i), 128'(count), 128'(8 - i));
        end
        step();
        chk("drained_rv", 128'(rd_valid), 128'(0));
        chk("drained_count", 128'(count), 128'(0));
        chk("drained_state", 128'(state), 128'(3));
        rd_en = 1'b0;

        // ---- circular wrap with overflow
        do_arm(1'b1, 1'b1, 32'h80);
        for (int p = 0; p <= 32'hA0; p += 4) begin
            do_retire(AW'(p));
            if (p == 32'h9C) chk("wrap_state_9c", 128'(state), 128'(2));
        end
        chk("wrap_state", 128'(state), 128'(3));
        chk("wrap_count", 128'(count), 128'(16));
        chk("wrap_ovf", 128'(overflow), 128'(1));
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("wrap_rv%0d", i), 128'(rd_valid), 128'(1));
            chk($sformatf("wrap_data%0d", i), 128'(rd_data), 128'(mk_entry(AW'(32'h64 + 4 * i))));
        end
        chk("wrap_count_end", 128'(count), 128'(0));
        step();
        chk("wrap_extra_rv", 128'(rd_valid), 128'(0));
        rd_en = 1'b0;
        do_arm(1'b0, 1'b1, 32'h0);
        chk("rearm_ovf", 128'(overflow), 128'(0));
        chk("rearm_state", 128'(state), 128'(1));
        chk("rearm_count", 128'(count), 128'(0));

        // ---- immediate trigger
        do_arm(1'b0, 1'b0, 32'hFFFF_FFFF);
        for (int p = 32'h100; p <= 32'h11C; p += 4) do_retire(AW'(p));
        chk("imm_state_11c", 128'(state), 128'(2));
        chk("imm_count_11c", 128'(count), 128'(8));
        do_retire(32'h120);
        chk("imm_state_120", 128'(state), 128'(3));
        chk("imm_count_120", 128'(count), 128'(9));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("imm_rv", 128'(rd_valid), 128'(1));
        chk("imm_first", 128'(rd_data), 128'(mk_entry(32'h100)));

        // ---- async reset mid-readout: no clock edge needed
        pulse_reset();
        chk("arst_rd_rv", 128'(rd_valid), 128'(0));
        chk("arst_rd_data", 128'(rd_data), 128'(0));
        chk("arst_rd_state", 128'(state), 128'(0));
        chk("arst_rd_count", 128'(count), 128'(0));
        #1 reset = 1'b0;

        // ---- async reset mid-capture
        do_arm(1'b0, 1'b0, 32'h0);
        do_retire(32'h200);
        do_retire(32'h204);
        chk("arst_pre_state", 128'(state), 128'(2));
        chk("arst_pre_count", 128'(count), 128'(2));
        pulse_reset();
        chk("arst_state", 128'(state), 128'(0));
        chk("arst_count", 128'(count), 128'(0));
        chk("arst_rv", 128'(rd_valid), 128'(0));
        #1 reset = 1'b0;
        do_retire(32'h208);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("post_rst_state", 128'(state), 128'(0));
        chk("post_rst_count", 128'(count), 128'(0));
        chk("post_rst_rv", 128'(rd_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
